// File: rtl/dmux_rr_dispatcher_pkg.sv
// Shared constants for the round-robin demux dispatcher.
// Optional timeout skipping is enabled by DMUX_DISPATCH_TIMEOUT_EN.
package dmux_rr_dispatcher_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int NUM_DEST    = 4;
  localparam int SEL_W       = 2;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/dmux_rr_dispatcher_timer.sv
// Stall timer for the dispatcher HOLD state.
// Instantiated only when DMUX_DISPATCH_TIMEOUT_EN is defined.
module dispatch_timer
  import dmux_rr_dispatcher_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/dmux_rr_dispatcher.sv
// Round-robin dispatcher driving the 4-way demux select and data.
// Define DMUX_DISPATCH_TIMEOUT_EN to skip destinations that stall.
module dmux_rr_dispatcher
  import dmux_rr_dispatcher_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  input  logic [NUM_DEST-1:0] dst_ready,
  output logic [SEL_W-1:0]    sel,
  output logic [WIDTH-1:0]    out_data,
  output logic [NUM_DEST-1:0] out_valid,
  output logic                busy,
  output logic [7:0]          skip_cnt
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic              hit;
  logic              skip;

  assign hit = dst_ready[sel];

`ifdef DMUX_DISPATCH_TIMEOUT_EN
  logic expired;
  logic t_clear;
  logic t_enable;

  assign t_enable = (state == ST_HOLD) && !hit;
  assign skip     = t_enable && expired;
  assign t_clear  = (state == ST_IDLE) || skip;

  dispatch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (t_clear),
    .enable  (t_enable),
    .expired (expired)
  );

  // Saturates so a permanently dead consumer never wraps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= '0;
    end else if (skip && skip_cnt != 8'hFF) begin
      skip_cnt <= skip_cnt + 8'd1;
    end
  end
`else
  assign skip     = 1'b0;
  assign skip_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      sel      <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            sel      <= ptr;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hit) begin
            ptr   <= sel + SEL_W'(1);
            state <= ST_IDLE;
          end else if (skip) begin
            sel <= sel + SEL_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state only.
  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_HOLD);
  assign out_valid = {NUM_DEST{busy}} & (NUM_DEST'(1) << sel);

endmodule
